// File: rtl/cpu_pkg.sv
// Shared types for the multicycle RV32I core: ALU operations, immediate
// formats, opcodes, controller states and datapath mux selects.
package cpu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SRL   = 4'd5,
      ALU_SRA   = 4'd6,
      ALU_OR    = 4'd7,
      ALU_AND   = 4'd8,
      ALU_BPASS = 4'd9
   } alu_op_t;

   typedef enum logic [2:0] {
      ADDI_SIGN_EXTEND = 3'd0,
      SW_SIGN_EXTEND   = 3'd1,
      BEQ_SIGN_EXTEND  = 3'd2,
      LUI_SIGN_EXTEND  = 3'd3,
      JAL_SIGN_EXTEND  = 3'd4,
      SLLI_SIGN_EXTEND = 3'd5
   } sign_extend_t;

   typedef enum logic [6:0] {
      OP_LOAD   = 7'b0000011,
      OP_IMM    = 7'b0010011,
      OP_STORE  = 7'b0100011,
      OP_REG    = 7'b0110011,
      OP_LUI    = 7'b0110111,
      OP_BRANCH = 7'b1100011,
      OP_JALR   = 7'b1100111,
      OP_JAL    = 7'b1101111
   } opcode_t;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADR   = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_EXEC_I    = 4'd7,
      S_ALU_WB    = 4'd8,
      S_JALR_ADR  = 4'd9,
      S_JUMP      = 4'd10,
      S_BRANCH    = 4'd11,
      S_HALT      = 4'd12
   } mcu_state_t;

   typedef enum logic [1:0] {
      SRC_A_PC     = 2'd0,
      SRC_A_OLD_PC = 2'd1,
      SRC_A_REG_A  = 2'd2
   } alu_src_a_t;

   typedef enum logic [1:0] {
      SRC_B_REG_B   = 2'd0,
      SRC_B_IMM_EXT = 2'd1,
      SRC_B_CONST_4 = 2'd2
   } alu_src_b_t;

   typedef enum logic [1:0] {
      RES_ALU_OUT    = 2'd0,
      RES_DATA       = 2'd1,
      RES_ALU_RESULT = 2'd2
   } result_sel_t;

   localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7 to an ALU operation for register and immediate forms,
// and flags the shift-immediate encodings that need their own immediate format.
module alu_decoder
   import cpu_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       is_imm,
   output alu_op_t    alu_op,
   output logic       shift_imm
);
   logic alt;

   assign alt       = (funct7 == FUNCT7_ALT);
   assign shift_imm = is_imm && ((funct3 == 3'b001) || (funct3 == 3'b101));

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      alu_op = ALU_ADD;
      unique case (funct3)
         3'b000: alu_op = (!is_imm && alt) ? ALU_SUB : ALU_ADD;
         3'b001: alu_op = ALU_SLL;
         3'b010: alu_op = ALU_SLT;
         3'b011: alu_op = ALU_SLT;
         3'b100: alu_op = ALU_XOR;
         3'b101: alu_op = (is_imm && alt) ? ALU_SRA : ALU_SRL;
         3'b110: alu_op = ALU_OR;
         3'b111: alu_op = ALU_AND;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I sequencer: steps each instruction through fetch, decode,
// execute, memory and writeback states over a shared instruction/data memory.
module multicycle_control_unit
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic        alu_eq,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        adr_src,
   output logic        ir_write,
   output logic        pc_write,
   output logic        reg_write,
   output logic        memory_write,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [3:0]  alu_op,
   output logic [2:0]  sign_extend_type,
   output logic [1:0]  result_sel,
   output logic        halted,
   output logic [31:0] retired_count,
   output logic [3:0]  state_check
);
   mcu_state_t   state, next_state;
   alu_src_a_t   src_a;
   alu_src_b_t   src_b;
   alu_op_t      op, dec_op;
   sign_extend_t ext;
   result_sel_t  rsel;
   logic         is_imm, dec_shift_imm, retire;
   logic         req, adr, irw, pcw, rw, mw;

   assign is_imm = (state == S_EXEC_I);

   alu_decoder u_alu_decoder (
      .funct3    (funct3),
      .funct7    (funct7),
      .is_imm    (is_imm),
      .alu_op    (dec_op),
      .shift_imm (dec_shift_imm)
   );

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (reset) begin
         state         <= S_FETCH;
         retired_count <= '0;
      end else begin
         state <= next_state;
         if (retire) retired_count <= retired_count + 32'd1;
      end
   end

   always_comb begin
      next_state = state;
      req        = 1'b0;
      adr        = 1'b0;
      irw        = 1'b0;
      pcw        = 1'b0;
      rw         = 1'b0;
      mw         = 1'b0;
      retire     = 1'b0;
      src_a      = SRC_A_PC;
      src_b      = SRC_B_REG_B;
      op         = ALU_ADD;
      ext        = ADDI_SIGN_EXTEND;
      rsel       = RES_ALU_OUT;

      case (state)
         S_FETCH: begin
            req   = 1'b1;
            src_b = SRC_B_CONST_4;
            rsel  = RES_ALU_RESULT;
            if (mem_ready) begin
               irw        = 1'b1;
               pcw        = 1'b1;
               next_state = S_DECODE;
            end
         end
         S_DECODE: begin
            // ALU_OUT captures OLD_PC + imm as the branch/JAL target.
            src_a = SRC_A_OLD_PC;
            src_b = SRC_B_IMM_EXT;
            case (opcode)
               OP_LOAD, OP_STORE: next_state = S_MEM_ADR;
               OP_REG:            next_state = S_EXEC_R;
               OP_IMM, OP_LUI:    next_state = S_EXEC_I;
               OP_JAL: begin
                  ext        = JAL_SIGN_EXTEND;
                  next_state = S_JUMP;
               end
               OP_JALR:           next_state = S_JALR_ADR;
               OP_BRANCH: begin
                  ext        = SW_SIGN_EXTEND;
                  next_state = S_BRANCH;
               end
               default:           next_state = S_HALT;
            endcase
         end
         S_MEM_ADR: begin
            src_a      = SRC_A_REG_A;
            src_b      = SRC_B_IMM_EXT;
            ext        = (opcode == OP_STORE) ? SW_SIGN_EXTEND : ADDI_SIGN_EXTEND;
            next_state = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            req = 1'b1;
            adr = 1'b1;
            if (mem_ready) next_state = S_MEM_WB;
         end
         S_MEM_WB: begin
            rsel       = RES_DATA;
            rw         = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         S_MEM_WRITE: begin
            req = 1'b1;
            adr = 1'b1;
            mw  = 1'b1;
            if (mem_ready) begin
               retire     = 1'b1;
               next_state = S_FETCH;
            end
         end
         S_EXEC_R: begin
            src_a      = SRC_A_REG_A;
            op         = dec_op;
            next_state = S_ALU_WB;
         end
         S_EXEC_I: begin
            src_a = SRC_A_REG_A;
            src_b = SRC_B_IMM_EXT;
            if (opcode == OP_LUI) begin
               op  = ALU_BPASS;
               ext = LUI_SIGN_EXTEND;
            end else begin
               op  = dec_op;
               ext = dec_shift_imm ? SLLI_SIGN_EXTEND : ADDI_SIGN_EXTEND;
            end
            next_state = S_ALU_WB;
         end
         S_ALU_WB: begin
            src_a      = SRC_A_OLD_PC;
            src_b      = SRC_B_CONST_4;
            rw         = 1'b1;
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         S_JALR_ADR: begin
            src_a      = SRC_A_REG_A;
            src_b      = SRC_B_IMM_EXT;
            next_state = S_JUMP;
         end
         S_JUMP: begin
            // PC takes the target held in ALU_OUT while the ALU forms the link address.
            src_a      = SRC_A_OLD_PC;
            src_b      = SRC_B_CONST_4;
            pcw        = 1'b1;
            next_state = S_ALU_WB;
         end
         S_BRANCH: begin
            src_a      = SRC_A_REG_A;
            op         = ALU_SUB;
            pcw        = ((funct3 == 3'b000) && alu_eq) || ((funct3 == 3'b001) && !alu_eq);
            retire     = 1'b1;
            next_state = S_FETCH;
         end
         S_HALT: next_state = S_HALT;
         default: next_state = S_FETCH;
      endcase
   end

   // A synchronous reset must squash any write the aborted state would make.
   assign mem_req          = req & ~reset;
   assign ir_write         = irw & ~reset;
   assign pc_write         = pcw & ~reset;
   assign reg_write        = rw & ~reset;
   assign memory_write     = mw & ~reset;
   assign adr_src          = adr;
   assign alu_src_a        = src_a;
   assign alu_src_b        = src_b;
   assign alu_op           = op;
   assign sign_extend_type = ext;
   assign result_sel       = rsel;
   assign halted           = (state == S_HALT);
   assign state_check      = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench for multicycle_control_unit: directed vector table,
// randomized instruction stream against a per-instruction cycle-trace model.
module tb_multicycle_control_unit;
   import cpu_pkg::*;

   logic        clk = 1'b0;
   logic        reset, alu_eq, mem_ready;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic        mem_req, adr_src, ir_write, pc_write, reg_write, memory_write, halted;
   logic [1:0]  alu_src_a, alu_src_b, result_sel;
   logic [3:0]  alu_op, state_check;
   logic [2:0]  sign_extend_type;
   logic [31:0] retired_count;

   multicycle_control_unit dut (
      .clk              (clk),
      .reset            (reset),
      .opcode           (opcode),
      .funct3           (funct3),
      .funct7           (funct7),
      .alu_eq           (alu_eq),
      .mem_ready        (mem_ready),
      .mem_req          (mem_req),
      .adr_src          (adr_src),
      .ir_write         (ir_write),
      .pc_write         (pc_write),
      .reg_write        (reg_write),
      .memory_write     (memory_write),
      .alu_src_a        (alu_src_a),
      .alu_src_b        (alu_src_b),
      .alu_op           (alu_op),
      .sign_extend_type (sign_extend_type),
      .result_sel       (result_sel),
      .halted           (halted),
      .retired_count    (retired_count),
      .state_check      (state_check)
   );

   always #5 clk = ~clk;

   typedef enum int {C_R, C_I, C_LUI, C_LW, C_SW, C_JAL, C_JALR, C_BR, C_ILL} iclass_t;

   // One expected clock cycle; *_care flags mark outputs the cycle actually defines.
   typedef struct packed {
      logic [3:0] st;
      logic       ready;
      logic       mem_req, adr_src, ir_write, pc_write, reg_write, memory_write, halted;
      logic       mux_care;
      logic [1:0] a, b;
      logic [3:0] op;
      logic       rsel_care;
      logic [1:0] rsel;
      logic       se_care;
      logic [2:0] se;
   } cyc_t;

   typedef struct {
      iclass_t    cls;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       eq;
      int         fw;
      int         mw;
      logic [3:0] xop;
      logic [2:0] xse;
   } vec_t;

   cyc_t exp_q[$];
   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;
   int   model_retired = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] opc_of(input iclass_t cls);
      case (cls)
         C_R:     return 7'h33;
         C_I:     return 7'h13;
         C_LUI:   return 7'h37;
         C_LW:    return 7'h03;
         C_SW:    return 7'h23;
         C_JAL:   return 7'h6F;
         C_JALR:  return 7'h67;
         C_BR:    return 7'h63;
         default: return 7'h7F;
      endcase
   endfunction

   // Reference ALU selection: base funct3 table plus the two funct7 alternates.
   function automatic logic [3:0] ref_op(input iclass_t cls, input logic [2:0] f3, input logic [6:0] f7);
      alu_op_t base [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLT, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      if (cls == C_LUI) return ALU_BPASS;
      if (cls == C_R && f3 == 3'd0 && f7 == 7'h20) return ALU_SUB;
      if (cls == C_I && f3 == 3'd5 && f7 == 7'h20) return ALU_SRA;
      return base[f3];
   endfunction

   function automatic logic [2:0] ref_se(input iclass_t cls, input logic [2:0] f3);
      if (cls == C_LUI) return LUI_SIGN_EXTEND;
      if (f3 == 3'd1 || f3 == 3'd5) return SLLI_SIGN_EXTEND;
      return ADDI_SIGN_EXTEND;
   endfunction

   function automatic cyc_t blank(input logic [3:0] st);
      cyc_t c = '0;
      c.st    = st;
      c.ready = 1'($urandom_range(0, 1));
      return c;
   endfunction

   function automatic cyc_t wb_cycle(input logic link);
      cyc_t c = blank(S_ALU_WB);
      c.reg_write = 1'b1;
      c.rsel_care = 1'b1;
      c.rsel      = RES_ALU_OUT;
      if (link) begin
         c.mux_care = 1'b1;
         c.a        = SRC_A_OLD_PC;
         c.b        = SRC_B_CONST_4;
         c.op       = ALU_ADD;
      end
      return c;
   endfunction

   // Expected cycle trace for one instruction, with fw fetch waits and mw memory waits.
   task automatic build(input iclass_t cls, input logic [2:0] f3, input logic eq, input logic [3:0] xop,
                        input logic [2:0] xse, input int fw, input int mw);
      cyc_t c;
      exp_q.delete();
      for (int i = 0; i <= fw; i++) begin
         c = blank(S_FETCH);
         c.mem_req   = 1'b1;
         c.mux_care  = 1'b1;
         c.a         = SRC_A_PC;
         c.b         = SRC_B_CONST_4;
         c.op        = ALU_ADD;
         c.rsel_care = 1'b1;
         c.rsel      = RES_ALU_RESULT;
         c.ready     = (i == fw);
         c.ir_write  = c.ready;
         c.pc_write  = c.ready;
         exp_q.push_back(c);
      end
      c = blank(S_DECODE);
      c.mux_care = 1'b1;
      c.a        = SRC_A_OLD_PC;
      c.b        = SRC_B_IMM_EXT;
      c.op       = ALU_ADD;
      exp_q.push_back(c);
      case (cls)
         C_R: begin
            c = blank(S_EXEC_R);
            c.mux_care = 1'b1; c.a = SRC_A_REG_A; c.b = SRC_B_REG_B; c.op = xop;
            exp_q.push_back(c);
            exp_q.push_back(wb_cycle(1'b0));
         end
         C_I, C_LUI: begin
            c = blank(S_EXEC_I);
            c.mux_care = 1'b1; c.a = SRC_A_REG_A; c.b = SRC_B_IMM_EXT; c.op = xop;
            c.se_care  = 1'b1; c.se = xse;
            exp_q.push_back(c);
            exp_q.push_back(wb_cycle(1'b0));
         end
         C_LW, C_SW: begin
            c = blank(S_MEM_ADR);
            c.mux_care = 1'b1; c.a = SRC_A_REG_A; c.b = SRC_B_IMM_EXT; c.op = ALU_ADD;
            c.se_care  = 1'b1; c.se = (cls == C_SW) ? SW_SIGN_EXTEND : ADDI_SIGN_EXTEND;
            exp_q.push_back(c);
            for (int i = 0; i <= mw; i++) begin
               c = blank((cls == C_SW) ? S_MEM_WRITE : S_MEM_READ);
               c.mem_req      = 1'b1;
               c.adr_src      = 1'b1;
               c.memory_write = (cls == C_SW);
               c.ready        = (i == mw);
               exp_q.push_back(c);
            end
            if (cls == C_LW) begin
               c = blank(S_MEM_WB);
               c.reg_write = 1'b1; c.rsel_care = 1'b1; c.rsel = RES_DATA;
               exp_q.push_back(c);
            end
         end
         C_JAL, C_JALR: begin
            if (cls == C_JALR) begin
               c = blank(S_JALR_ADR);
               c.mux_care = 1'b1; c.a = SRC_A_REG_A; c.b = SRC_B_IMM_EXT; c.op = ALU_ADD;
               exp_q.push_back(c);
            end
            c = blank(S_JUMP);
            c.pc_write  = 1'b1;
            c.rsel_care = 1'b1; c.rsel = RES_ALU_OUT;
            c.mux_care  = 1'b1; c.a = SRC_A_OLD_PC; c.b = SRC_B_CONST_4; c.op = ALU_ADD;
            exp_q.push_back(c);
            exp_q.push_back(wb_cycle(1'b1));
         end
         C_BR: begin
            c = blank(S_BRANCH);
            c.mux_care  = 1'b1; c.a = SRC_A_REG_A; c.b = SRC_B_REG_B; c.op = ALU_SUB;
            c.rsel_care = 1'b1; c.rsel = RES_ALU_OUT;
            c.pc_write  = (f3 == 3'd0 && eq) || (f3 == 3'd1 && !eq);
            exp_q.push_back(c);
         end
         default: ;
      endcase
   endtask

   task automatic apply(input cyc_t c, input string tag);
      mem_ready = c.ready;
      @(negedge clk);
      check({tag, " state"}, 32'(state_check), 32'(c.st));
      check({tag, " enables"}, {27'd0, mem_req, ir_write, pc_write, reg_write, memory_write},
            {27'd0, c.mem_req, c.ir_write, c.pc_write, c.reg_write, c.memory_write});
      check({tag, " halted"}, 32'(halted), 32'(c.halted));
      if (c.mem_req) check({tag, " adr_src"}, 32'(adr_src), 32'(c.adr_src));
      if (c.mux_care) check({tag, " alu a/b/op"}, {24'd0, alu_src_a, alu_src_b, alu_op}, {24'd0, c.a, c.b, c.op});
      if (c.rsel_care) check({tag, " result_sel"}, 32'(result_sel), 32'(c.rsel));
      if (c.se_care) check({tag, " sign_extend"}, 32'(sign_extend_type), 32'(c.se));
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input iclass_t cls, input logic [2:0] f3, input logic [6:0] f7, input logic eq,
                            input logic [3:0] xop, input logic [2:0] xse, input int fw, input int mw,
                            input string tag);
      opcode = opc_of(cls);
      funct3 = f3;
      funct7 = f7;
      alu_eq = eq;
      build(cls, f3, eq, xop, xse, fw, mw);
      foreach (exp_q[i]) apply(exp_q[i], $sformatf("%s c%0d", tag, i));
      model_retired++;
      check({tag, " retired"}, retired_count, 32'(model_retired));
      check({tag, " back to fetch"}, 32'(state_check), 32'(S_FETCH));
   endtask

   task automatic do_reset(input string tag);
      reset     = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      check({tag, " enables in reset"}, {27'd0, mem_req, ir_write, pc_write, reg_write, memory_write}, 32'd0);
      @(posedge clk);
      #1;
      reset         = 1'b0;
      model_retired = 0;
      check({tag, " state"}, 32'(state_check), 32'(S_FETCH));
      check({tag, " halted"}, 32'(halted), 32'd0);
      check({tag, " retired"}, retired_count, 32'd0);
   endtask

   task automatic add_vec(input iclass_t cls, input logic [2:0] f3, input logic [6:0] f7, input logic eq,
                          input int fw, input int mw, input logic [3:0] xop, input logic [2:0] xse);
      vec_t v;
      v.cls = cls; v.f3 = f3; v.f7 = f7; v.eq = eq; v.fw = fw; v.mw = mw; v.xop = xop; v.xse = xse;
      vecs.push_back(v);
   endtask

   task automatic random_instr(input int n);
      iclass_t    cls;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       eq;
      int         fw, mw;
      cls = iclass_t'($urandom_range(0, 7));
      f3  = 3'($urandom);
      f7  = 7'h00;
      eq  = 1'($urandom);
      if (cls == C_R && f3 == 3'd0 && $urandom_range(0, 1) == 1) f7 = 7'h20;
      if (cls == C_I && f3 == 3'd5 && $urandom_range(0, 1) == 1) f7 = 7'h20;
      if (cls == C_BR && $urandom_range(0, 3) != 0) f3 = {2'b00, f3[0]};
      fw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      mw = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_instr(cls, f3, f7, eq, ref_op(cls, f3, f7), ref_se(cls, f3), fw, mw, $sformatf("rand%0d", n));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      cyc_t c;
      reset = 1'b1; mem_ready = 1'b0; opcode = '0; funct3 = '0; funct7 = '0; alu_eq = 1'b0;

      add_vec(C_I,    3'd0, 7'h00, 1'b0, 0, 0, ALU_ADD,   ADDI_SIGN_EXTEND);  // addi x1,x0,5
      add_vec(C_LW,   3'd2, 7'h00, 1'b0, 0, 3, ALU_ADD,   ADDI_SIGN_EXTEND);  // lw, 3 wait cycles
      add_vec(C_BR,   3'd0, 7'h00, 1'b1, 0, 0, ALU_SUB,   ADDI_SIGN_EXTEND);  // beq taken
      add_vec(C_BR,   3'd1, 7'h00, 1'b1, 0, 0, ALU_SUB,   ADDI_SIGN_EXTEND);  // bne not taken
      add_vec(C_JAL,  3'd0, 7'h00, 1'b0, 0, 0, ALU_ADD,   ADDI_SIGN_EXTEND);
      add_vec(C_JALR, 3'd0, 7'h00, 1'b0, 0, 0, ALU_ADD,   ADDI_SIGN_EXTEND);
      add_vec(C_SW,   3'd2, 7'h00, 1'b0, 1, 2, ALU_ADD,   ADDI_SIGN_EXTEND);
      add_vec(C_SW,   3'd2, 7'h00, 1'b0, 0, 0, ALU_ADD,   ADDI_SIGN_EXTEND);
      add_vec(C_BR,   3'd0, 7'h00, 1'b0, 0, 0, ALU_SUB,   ADDI_SIGN_EXTEND);
      add_vec(C_BR,   3'd1, 7'h00, 1'b0, 2, 0, ALU_SUB,   ADDI_SIGN_EXTEND);
      add_vec(C_BR,   3'd4, 7'h00, 1'b1, 0, 0, ALU_SUB,   ADDI_SIGN_EXTEND);
      add_vec(C_BR,   3'd5, 7'h00, 1'b0, 0, 0, ALU_SUB,   ADDI_SIGN_EXTEND);
      add_vec(C_R,    3'd0, 7'h00, 1'b0, 0, 0, ALU_ADD,   ADDI_SIGN_EXTEND);
      add_vec(C_R,    3'd0, 7'h20, 1'b0, 0, 0, ALU_SUB,   ADDI_SIGN_EXTEND);
      add_vec(C_R,    3'd1, 7'h00, 1'b0, 0, 0, ALU_SLL,   ADDI_SIGN_EXTEND);
      add_vec(C_R,    3'd2, 7'h00, 1'b0, 0, 0, ALU_SLT,   ADDI_SIGN_EXTEND);
      add_vec(C_R,    3'd3, 7'h00, 1'b0, 0, 0, ALU_SLT,   ADDI_SIGN_EXTEND);
      add_vec(C_R,    3'd4, 7'h00, 1'b0, 0, 0, ALU_XOR,   ADDI_SIGN_EXTEND);
      add_vec(C_R,    3'd5, 7'h00, 1'b0, 0, 0, ALU_SRL,   ADDI_SIGN_EXTEND);
      add_vec(C_R,    3'd6, 7'h00, 1'b0, 0, 0, ALU_OR,    ADDI_SIGN_EXTEND);
      add_vec(C_R,    3'd7, 7'h00, 1'b0, 0, 0, ALU_AND,   ADDI_SIGN_EXTEND);
      add_vec(C_I,    3'd1, 7'h00, 1'b0, 0, 0, ALU_SLL,   SLLI_SIGN_EXTEND);
      add_vec(C_I,    3'd5, 7'h00, 1'b0, 0, 0, ALU_SRL,   SLLI_SIGN_EXTEND);
      add_vec(C_I,    3'd5, 7'h20, 1'b0, 0, 0, ALU_SRA,   SLLI_SIGN_EXTEND);
      add_vec(C_I,    3'd3, 7'h00, 1'b0, 0, 0, ALU_SLT,   ADDI_SIGN_EXTEND);
      add_vec(C_I,    3'd4, 7'h00, 1'b0, 0, 0, ALU_XOR,   ADDI_SIGN_EXTEND);
      add_vec(C_I,    3'd6, 7'h00, 1'b0, 0, 0, ALU_OR,    ADDI_SIGN_EXTEND);
      add_vec(C_I,    3'd7, 7'h00, 1'b0, 0, 0, ALU_AND,   ADDI_SIGN_EXTEND);
      add_vec(C_LUI,  3'd5, 7'h20, 1'b0, 0, 0, ALU_BPASS, LUI_SIGN_EXTEND);
      add_vec(C_LW,   3'd2, 7'h00, 1'b0, 2, 0, ALU_ADD,   ADDI_SIGN_EXTEND);

      repeat (2) @(posedge clk);
      #1;
      do_reset("por");

      foreach (vecs[i])
         run_instr(vecs[i].cls, vecs[i].f3, vecs[i].f7, vecs[i].eq, vecs[i].xop, vecs[i].xse,
                   vecs[i].fw, vecs[i].mw, $sformatf("vec%0d", i));

      for (int n = 0; n < 300; n++) random_instr(n);

      // Illegal opcode: decode, then ten cycles parked in HALT, then reset recovers.
      opcode = 7'h7F; funct3 = 3'd0; funct7 = 7'h00;
      build(C_ILL, 3'd0, 1'b0, ALU_ADD, ADDI_SIGN_EXTEND, 0, 0);
      foreach (exp_q[i]) apply(exp_q[i], $sformatf("illegal c%0d", i));
      for (int i = 0; i < 10; i++) begin
         c = blank(S_HALT);
         c.halted = 1'b1;
         apply(c, $sformatf("halt%0d", i));
      end
      check("halt retired unchanged", retired_count, 32'(model_retired));
      do_reset("halt reset");

      // Reset landing on the MEM_WRITE completion cycle must suppress the store.
      opcode = 7'h23; funct3 = 3'd2; funct7 = 7'h00;
      build(C_SW, 3'd2, 1'b0, ALU_ADD, ADDI_SIGN_EXTEND, 0, 0);
      for (int i = 0; i < 3; i++) apply(exp_q[i], $sformatf("sw abort c%0d", i));
      reset     = 1'b1;
      mem_ready = 1'b1;
      @(negedge clk);
      check("sw abort state", 32'(state_check), 32'(S_MEM_WRITE));
      check("sw abort memory_write", 32'(memory_write), 32'd0);
      check("sw abort enables", {27'd0, mem_req, ir_write, pc_write, reg_write, memory_write}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("sw abort next state", 32'(state_check), 32'(S_FETCH));
      check("sw abort retired", retired_count, 32'd0);

      run_instr(C_I, 3'd0, 7'h00, 1'b0, ALU_ADD, ADDI_SIGN_EXTEND, 0, 0, "recover addi");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Sequencing controller for the multicycle variant of the RV32I core. Replaces the single-cycle combinational control unit: steps one instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over 3-5+ cycles, driving enables and mux selects of a datapath with one shared instruction/data memory, an instruction register, and ALU/memory holding registers. Handles a ready handshake with the shared memory, halts on illegal opcodes, and counts retired instructions.

## Interface
- No parameters.
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- alu_eq  in  1  ALU equality flag (rs1 == rs2)
- mem_ready  in  1  shared memory completes current access this cycle
- mem_req  out  1  memory access valid
- adr_src  out  1  0 = PC, 1 = ALU_OUT register
- ir_write  out  1  latch instruction and old_pc
- pc_write  out  1  PC <= result bus
- reg_write  out  1  register file write
- memory_write  out  1  store strobe
- alu_src_a  out  2  0 PC, 1 OLD_PC, 2 REG_A
- alu_src_b  out  2  0 REG_B, 1 IMM_EXT, 2 CONST_4
- alu_op  out  4  alu_op_t
- sign_extend_type  out  3  sign_extend_t
- result_sel  out  2  0 ALU_OUT reg, 1 DATA reg, 2 live ALU result
- halted  out  1  sticky illegal-opcode flag
- retired_count  out  32  retired-instruction count
- state_check  out  4  current state, for the bench

## Operation
- States: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, JALR_ADR, JUMP, BRANCH, HALT.
- FETCH: mem_req=1, adr_src=0, src_a=PC, src_b=4, alu_op=ADD, result_sel=2. Waits while mem_ready=0, with all enables low. When mem_ready=1, ir_write=1 and pc_write=1, then -> DECODE.
- DECODE: src_a=OLD_PC, src_b=IMM_EXT, alu_op=ADD, so ALU_OUT gets the branch/JAL target. For BEQ opcode, sign_extend_type=SW_SIGN_EXTEND is don't-care because the datapath has a separate B-immediate path.
  - LW/SW -> MEM_ADR
  - R-type -> EXEC_R
  - I-type/LUI -> EXEC_I
  - JAL -> JUMP
  - JALR -> JALR_ADR
  - BEQ/BNE -> BRANCH
  - anything else -> HALT
- MEM_ADR: src_a=REG_A, src_b=IMM_EXT, ADD. Sign extend is SW type for SW, ADDI type for LW. LW -> MEM_READ, SW -> MEM_WRITE.
- MEM_READ: mem_req=1, adr_src=1. Holds until mem_ready, then -> MEM_WB.
- MEM_WB: result_sel=1, reg_write=1 -> FETCH.
- MEM_WRITE: mem_req=1, adr_src=1, memory_write=1 while waiting. -> FETCH on mem_ready.
- EXEC_R: src_a=REG_A, src_b=REG_B. alu_op from funct3/funct7: 000 ADD/SUB (funct7 0100000), 001 SLL, 010/011 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND. -> ALU_WB.
- EXEC_I: src_a=REG_A, src_b=IMM_EXT.
  - Immediate ALU ops use the same funct3 mapping; 101 selects SRA when funct7=0100000.
  - SLLI/SRLI/SRAI use SLLI_SIGN_EXTEND.
  - LUI uses BPASS + LUI_SIGN_EXTEND.
  - -> ALU_WB.
- ALU_WB: result_sel=0, reg_write=1 -> FETCH.
- JALR_ADR: REG_A + IMM_EXT -> ALU_OUT; -> JUMP.
- JUMP: result_sel=0, pc_write=1 (PC <= target). ALU computes OLD_PC+4 (src_a=1, src_b=2). -> ALU_WB.
- BRANCH: src_a=REG_A, src_b=REG_B, alu_op=SUB, result_sel=0. pc_write = (funct3==000 & alu_eq) | (funct3==001 & !alu_eq); other funct3 never writes. -> FETCH.
- HALT: all enables 0, mem_req=0, halted=1; stays until reset.
- retired_count increments by 1 on the final cycle of each instruction: the cycle whose successor is FETCH and in which no wait is pending. Wraps 0xFFFFFFFF -> 0.
- Outputs are Moore, except the BRANCH pc_write, ir_write/pc_write gated by mem_ready in FETCH, and the MEM_WRITE exit.

## Timing
- Reset: state=FETCH, retired_count=0, halted=0. Every enable is 0 during the reset cycle.
- Reset mid-instruction aborts it with no write. A reset that coincides with mem_ready=1 still suppresses ir_write, pc_write and memory_write.
- Cycles with zero-wait memory: LW 5, SW 4, R/I/LUI 4, BEQ/BNE 3, JAL 4, JALR 5. Each mem_ready=0 cycle adds 1.
- memory_write stays asserted throughout a MEM_WRITE wait. The memory commits only on the mem_ready cycle.

## Structure
- Shared package cpu_pkg holds: alu_op_t, sign_extend_t, opcode_t, mcu_state_t, alu_src_a_t, alu_src_b_t, result_sel_t.
- Sub-module alu_decoder (combinational funct3/funct7 -> alu_op, plus shift-immediate select), shared by EXEC_R and EXEC_I.

## Test plan
- addi x1,x0,5 with mem_ready tied 1 -> FETCH, DECODE, EXEC_I, ALU_WB; reg_write=1 in cycle 4; retired_count=1.
- lw, with mem_ready held 0 for 3 cycles in MEM_READ -> 8 cycles total; reg_write only in MEM_WB; result_sel=1.
- beq with alu_eq=1, then bne with alu_eq=1 -> pc_write=1 in BRANCH for beq, 0 for bne; each 3 cycles.
- jal -> pc_write in FETCH and JUMP; reg_write in ALU_WB with src_a=1, src_b=2.
- opcode 0x7F -> DECODE then HALT; halted=1 and all enables 0 for 10 cycles; reset returns state to FETCH and halted=0.
- Reset asserted in MEM_WRITE with mem_ready=1 -> memory_write=0 that cycle; next state FETCH; retired_count unchanged at 0.
